// File: rtl/multicycle_controller_pkg.sv
`default_nettype none
// ============================================================================
// multicycle_controller_pkg : shared encodings and Moore output table
// Rev 1.0 - initial release
// ============================================================================
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALUC_ADD = 3'b000;
  localparam logic [2:0] ALUC_SUB = 3'b001;
  localparam logic [2:0] ALUC_AND = 3'b010;
  localparam logic [2:0] ALUC_OR  = 3'b011;
  localparam logic [2:0] ALUC_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  // fetch and branch are qualifiers, combined with MemReady / Zero at the top
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       fetch;
    logic       pc_write;
    logic       branch;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

  function automatic ctrl_t moore_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req    = 1'b1;
        c.fetch      = 1'b1;
        c.alu_src_a  = SRCA_PC;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALURES;
        c.alu_op     = ALUOP_ADD;
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        c.mem_req = 1'b1;
        c.adr_src = 1'b1;
      end
      S_MEMWB: begin
        c.result_src = RES_DATA;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.mem_req   = 1'b1;
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXECR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_RS2;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.result_src = RES_ALUOUT;
        c.reg_write  = 1'b1;
      end
      S_JAL: begin
        c.alu_src_a  = SRCA_OLDPC;
        c.alu_src_b  = SRCB_FOUR;
        c.alu_op     = ALUOP_ADD;
        c.result_src = RES_ALUOUT;
        c.pc_write   = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a  = SRCA_RS1;
        c.alu_src_b  = SRCB_RS2;
        c.alu_op     = ALUOP_SUB;
        c.result_src = RES_ALUOUT;
        c.branch     = 1'b1;
      end
      S_HALT: c.illegal = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_controller_alu_decoder.sv
`default_nettype none
// ============================================================================
// alu_decoder : maps ALUOp plus instruction function fields to ALUControl
// Rev 1.0 - initial release
// ============================================================================
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_op_b5,
  input  logic       i_funct7_b5,
  output logic [2:0] o_alu_control
);

  always_comb begin
    o_alu_control = ALUC_ADD;
    case (i_alu_op)
      ALUOP_SUB: o_alu_control = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          // Op[5] separates R-type sub from addi, which has no funct7 field
          3'b000:  o_alu_control = (i_op_b5 & i_funct7_b5) ? ALUC_SUB : ALUC_ADD;
          3'b010:  o_alu_control = ALUC_SLT;
          3'b110:  o_alu_control = ALUC_OR;
          3'b111:  o_alu_control = ALUC_AND;
          default: o_alu_control = ALUC_ADD;
        endcase
      end
      default: o_alu_control = ALUC_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// multicycle_controller : multicycle RISC-V main control FSM with MemReady
// Rev 1.0 - initial release
// ============================================================================
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic [6:0] Op,
  input  logic [2:0] Funct3,
  input  logic       Funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       Illegal,
  output logic [3:0] State
);

  state_t     state_q, state_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic [2:0] w_alu_control;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_HALT;
        endcase
      end
      S_MEMADR:   state_d = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (MemReady) state_d = S_MEMWB;
      S_MEMWRITE: if (MemReady) state_d = S_FETCH;
      S_MEMWB, S_BEQ, S_ALUWB:   state_d = S_FETCH;
      S_EXECR, S_EXECI, S_JAL:   state_d = S_ALUWB;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_HALT;
    endcase
    // outputs are registered alongside the state they belong to
    ctrl_d = moore_ctrl(state_d);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= moore_ctrl(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  alu_decoder u_alu_decoder (
    .i_alu_op      (ctrl_q.alu_op),
    .i_funct3      (Funct3),
    .i_op_b5       (Op[5]),
    .i_funct7_b5   (Funct7b5),
    .o_alu_control (w_alu_control)
  );

  always_comb begin
    case (Op)
      OP_SW:   ImmSrc = IMM_S;
      OP_BEQ:  ImmSrc = IMM_B;
      OP_JAL:  ImmSrc = IMM_J;
      default: ImmSrc = IMM_I;
    endcase
  end

  assign MemReq     = ctrl_q.mem_req;
  assign MemWrite   = ctrl_q.mem_write;
  assign AdrSrc     = ctrl_q.adr_src;
  assign IRWrite    = ctrl_q.fetch & MemReady;
  assign PCWrite    = ctrl_q.pc_write | (ctrl_q.fetch & MemReady) | (ctrl_q.branch & Zero);
  assign RegWrite   = ctrl_q.reg_write;
  assign ResultSrc  = ctrl_q.result_src;
  assign ALUSrcA    = ctrl_q.alu_src_a;
  assign ALUSrcB    = ctrl_q.alu_src_b;
  assign ALUControl = w_alu_control;
  assign Illegal    = ctrl_q.illegal;
  assign State      = state_q;

endmodule
`default_nettype wire
